// File: rtl/cnu_serial.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : cnu_serial                                                    |
// | Description : Serial offset min-sum LDPC check-node unit. Accumulates DEG   |
// |               sign-magnitude messages, then emits DEG extrinsic replies.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module cnu_serial #(
  parameter int DEG    = 6,
  parameter int IN_W   = 6,
  parameter int OUT_W  = 5,
  parameter int OFFSET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_msg,
  output logic             out_last,
  output logic             p_bit
);

  localparam int MAG_W  = IN_W - 1;
  localparam int OMAG_W = OUT_W - 1;
  localparam int CNT_W  = (DEG > 1) ? $clog2(DEG) : 1;

  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(DEG - 1);
  localparam logic [MAG_W-1:0] C_ONES   = '1;
  localparam logic [MAG_W-1:0] C_OFF    = MAG_W'(OFFSET);
  localparam logic [MAG_W-1:0] C_OSAT   = MAG_W'((1 << OMAG_W) - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] idx1_q,    idx1_d;
  logic [MAG_W-1:0] min1_q,    min1_d;
  logic [MAG_W-1:0] min2_q,    min2_d;
  logic             par_q,     par_d;
  logic [DEG-1:0]   sign_q,    sign_d;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_emit;
  logic [MAG_W-1:0] w_in_mag;
  logic             w_in_sgn;
  logic [MAG_W-1:0] w_sel_mag;
  logic [MAG_W-1:0] w_off_mag;
  logic [OMAG_W-1:0] w_sat_mag;

  assign w_emit     = (state_q == ST_EMIT);
  assign in_ready   = en & ~rst & ~w_emit;
  assign out_valid  = en & w_emit;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_in_mag   = in_msg[MAG_W-1:0];
  assign w_in_sgn   = in_msg[IN_W-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_idx_d = out_idx_q;
    idx1_d    = idx1_q;
    min1_d    = min1_q;
    min2_d    = min2_q;
    par_d     = par_q;
    sign_d    = sign_q;

    if (w_in_fire) begin
      par_d         = par_q ^ w_in_sgn;
      sign_d[cnt_q] = w_in_sgn;
      // Strict compares keep the earliest minimum as idx1 on ties.
      if (w_in_mag < min1_q) begin
        min2_d = min1_q;
        min1_d = w_in_mag;
        idx1_d = cnt_q;
      end else if (w_in_mag < min2_q) begin
        min2_d = w_in_mag;
      end
      if (cnt_q == C_LAST) begin
        cnt_d     = '0;
        out_idx_d = '0;
        state_d   = ST_EMIT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (w_out_fire) begin
      if (out_idx_q == C_LAST) begin
        state_d   = ST_ACCUM;
        out_idx_d = '0;
        cnt_d     = '0;
        idx1_d    = '0;
        min1_d    = C_ONES;
        min2_d    = C_ONES;
        par_d     = 1'b0;
        sign_d    = '0;
      end else begin
        out_idx_d = out_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      cnt_q     <= '0;
      out_idx_q <= '0;
      idx1_q    <= '0;
      min1_q    <= C_ONES;
      min2_q    <= C_ONES;
      par_q     <= 1'b0;
      sign_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_idx_q <= out_idx_d;
      idx1_q    <= idx1_d;
      min1_q    <= min1_d;
      min2_q    <= min2_d;
      par_q     <= par_d;
      sign_q    <= sign_d;
    end
  end

  // Extrinsic magnitude: exclude this edge's own contribution, offset, then saturate.
  assign w_sel_mag = (out_idx_q == idx1_q) ? min2_q : min1_q;
  assign w_off_mag = (w_sel_mag > C_OFF) ? (w_sel_mag - C_OFF) : '0;
  assign w_sat_mag = (w_off_mag > C_OSAT) ? {OMAG_W{1'b1}} : w_off_mag[OMAG_W-1:0];

  assign out_msg  = w_emit ? {par_q ^ sign_q[out_idx_q], w_sat_mag} : '0;
  assign out_last = w_emit & (out_idx_q == C_LAST);
  assign p_bit    = par_q;

endmodule
`default_nettype wire
